// File: rtl/mem_pkg.sv
// Shared types and limits for the pipelined single-port RAM and its read pipeline.
package mem_pkg;

    localparam int MAX_RD_LATENCY = 4;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // One accepted request as seen on the cycle it is sampled.
    typedef struct packed {
        logic rd;
        logic wr;
        logic oor;
    } req_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Delay line for read valid/data/error behind the array read register.
// Each stage's data only moves with a valid beat, so the output holds its last read.
module mem_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_err,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign out_err   = in_err;
        end else begin : g_pipe
            for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
                logic                  valid_d;
                logic                  err_d;
                logic [DATA_WIDTH-1:0] data_d;
                logic                  valid_q;
                logic                  err_q;
                logic [DATA_WIDTH-1:0] data_q;

                if (gi == 0) begin : g_head
                    assign valid_d = in_valid;
                    assign err_d   = in_err;
                    assign data_d  = in_data;
                end else begin : g_link
                    assign valid_d = g_stage[gi-1].valid_q;
                    assign err_d   = g_stage[gi-1].err_q;
                    assign data_d  = g_stage[gi-1].data_q;
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        data_q  <= '0;
                    end else begin
                        valid_q <= valid_d;
                        err_q   <= err_d;
                        if (valid_d) begin
                            data_q <= data_d;
                        end
                    end
                end
            end

            assign out_valid = g_stage[STAGES-1].valid_q;
            assign out_data  = g_stage[STAGES-1].data_q;
            assign out_err   = g_stage[STAGES-1].err_q;
        end
    endgenerate

endmodule

// File: rtl/mem_pipe_ram.sv
// Single-port RAM with byte enables, post-reset zero fill, out-of-range flagging
// and a configurable read latency with an aligned valid strobe.
module mem_pipe_ram
    import mem_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 4,
    parameter int                   ADDR_DEPTH = 16,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    EN,
    input  logic                    WR,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    input  logic [DATA_WIDTH/8-1:0] BE,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    Valid_out,
    output logic                    Busy,
    output logic                    Err
);

    localparam int BE_WIDTH = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 ||
            ADDR_DEPTH < 1 || ADDR_DEPTH > (2 ** ADDR_WIDTH) ||
            RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_params
            $fatal(1, "mem_pipe_ram: illegal DATA_WIDTH, ADDR_DEPTH or RD_LATENCY");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  busy_reg;
    req_t                  req;

    // With a fully populated address space LAST_ADDR is all ones, so this folds to 0.
    logic oor;
    assign oor = (Address > LAST_ADDR);

    always_comb begin
        req     = '0;
        req.rd  = (state == RUN) && EN && !WR;
        req.wr  = (state == RUN) && EN && WR;
        req.oor = (state == RUN) && EN && oor;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            fill_cnt <= '0;
            busy_reg <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == LAST_ADDR) begin
                        state    <= RUN;
                        busy_reg <= 1'b0;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign Busy = busy_reg;

    // The fill owns the write port until RUN; afterwards only in-range writes land.
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   wbe;

    always_comb begin
        we    = 1'b0;
        waddr = Address;
        wdata = Data_in;
        wbe   = BE;
        if (state == INIT) begin
            we    = 1'b1;
            waddr = fill_cnt;
            wdata = INIT_VALUE;
            wbe   = '1;
        end else begin
            we = req.wr && !req.oor;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Array read register: the first latency stage; later stages live in mem_rd_pipe.
    logic                  s0_valid;
    logic                  s0_err;
    logic [DATA_WIDTH-1:0] s0_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_err   <= 1'b0;
            s0_data  <= '0;
        end else begin
            s0_valid <= req.rd;
            s0_err   <= req.oor;
            if (req.rd) begin
                s0_data <= req.oor ? '0 : mem[Address];
            end
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_valid),
        .in_data   (s0_data),
        .in_err    (s0_err),
        .out_valid (Valid_out),
        .out_data  (Data_out),
        .out_err   (Err)
    );

endmodule

// File: tb/tb_mem_pipe_ram.sv
// Directed bench: three RAM configurations share one stimulus stream and are
// checked against hand-computed expectations.
module tb_mem_pipe_ram;

    localparam logic [31:0] INIT3 = 32'hC0DE_0001;

    logic        clk;
    logic        rst;
    logic        EN;
    logic        WR;
    logic [3:0]  Address;
    logic [31:0] Data_in;
    logic [3:0]  BE;

    logic [31:0] d1, d3, d12;
    logic        v1, v3, v12;
    logic        b1, b3, b12;
    logic        e1, e3, e12;

    int n_vec  = 0;
    int n_fail = 0;

    mem_pipe_ram #(.ADDR_WIDTH(4), .ADDR_DEPTH(16), .DATA_WIDTH(32), .RD_LATENCY(1), .INIT_VALUE(32'h0)) dut1 (
        .clk(clk), .rst(rst), .EN(EN), .WR(WR), .Address(Address), .Data_in(Data_in), .BE(BE),
        .Data_out(d1), .Valid_out(v1), .Busy(b1), .Err(e1));

    mem_pipe_ram #(.ADDR_WIDTH(4), .ADDR_DEPTH(16), .DATA_WIDTH(32), .RD_LATENCY(3), .INIT_VALUE(INIT3)) dut3 (
        .clk(clk), .rst(rst), .EN(EN), .WR(WR), .Address(Address), .Data_in(Data_in), .BE(BE),
        .Data_out(d3), .Valid_out(v3), .Busy(b3), .Err(e3));

    mem_pipe_ram #(.ADDR_WIDTH(4), .ADDR_DEPTH(12), .DATA_WIDTH(32), .RD_LATENCY(1), .INIT_VALUE(32'h0)) dut12 (
        .clk(clk), .rst(rst), .EN(EN), .WR(WR), .Address(Address), .Data_in(Data_in), .BE(BE),
        .Data_out(d12), .Valid_out(v12), .Busy(b12), .Err(e12));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic en, input logic wr, input logic [3:0] addr,
                                input logic [31:0] din, input logic [3:0] be,
                                input logic exp_v, input logic [31:0] exp_d);
        vec_t r;
        r.en = en; r.wr = wr; r.addr = addr; r.din = din; r.be = be;
        r.exp_v = exp_v; r.exp_d = exp_d;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 4'd5,  32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000);
        tbl[1]  = mk(1, 0, 4'd5,  32'h0,         4'h0, 1, 32'hDEAD_BEEF);
        tbl[2]  = mk(1, 1, 4'd7,  32'hAABB_CCDD, 4'hF, 0, 32'hDEAD_BEEF);
        tbl[3]  = mk(1, 1, 4'd7,  32'h1122_3344, 4'h5, 0, 32'hDEAD_BEEF);
        tbl[4]  = mk(1, 0, 4'd7,  32'h0,         4'h0, 1, 32'hAA22_CC44);
        tbl[5]  = mk(0, 1, 4'd7,  32'h0,         4'hF, 0, 32'hAA22_CC44);
        tbl[6]  = mk(1, 0, 4'd7,  32'h0,         4'h0, 1, 32'hAA22_CC44);
        tbl[7]  = mk(1, 1, 4'd7,  32'hFFFF_FFFF, 4'h0, 0, 32'hAA22_CC44);
        tbl[8]  = mk(1, 0, 4'd7,  32'h0,         4'h0, 1, 32'hAA22_CC44);
        tbl[9]  = mk(1, 1, 4'd0,  32'h0000_000A, 4'hF, 0, 32'hAA22_CC44);
        tbl[10] = mk(1, 1, 4'd1,  32'h0000_000B, 4'hF, 0, 32'hAA22_CC44);
        tbl[11] = mk(1, 1, 4'd2,  32'h0000_000C, 4'hF, 0, 32'hAA22_CC44);
        tbl[12] = mk(1, 0, 4'd15, 32'h0,         4'h0, 1, 32'h0000_0000);
        tbl[13] = mk(1, 1, 4'd15, 32'h1234_5678, 4'h8, 0, 32'h0000_0000);
        tbl[14] = mk(1, 0, 4'd15, 32'h0,         4'h0, 1, 32'h1200_0000);
        tbl[15] = mk(1, 0, 4'd0,  32'h0,         4'h0, 1, 32'h0000_000A);
        tbl[16] = mk(1, 0, 4'd1,  32'h0,         4'h0, 1, 32'h0000_000B);
        tbl[17] = mk(1, 0, 4'd2,  32'h0,         4'h0, 1, 32'h0000_000C);

        rst = 1'b0; EN = 1'b0; WR = 1'b0; Address = '0; Data_in = '0; BE = '0;
        repeat (3) step();

        chk("reset busy1", b1, 1);
        chk("reset busy3", b3, 1);
        chk("reset busy12", b12, 1);
        chk("reset valid1", v1, 0);
        chk("reset data1", d1, 0);
        chk("reset err12", e12, 0);

        // Fill with a write request held on the inputs throughout.
        EN = 1; WR = 1; Address = 4'd3; Data_in = 32'hFFFF_FFFF; BE = 4'hF;
        rst = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            chk($sformatf("fill busy1 c%0d", i), b1, (i < 16) ? 1 : 0);
            chk($sformatf("fill busy3 c%0d", i), b3, (i < 16) ? 1 : 0);
            chk($sformatf("fill busy12 c%0d", i), b12, (i < 12) ? 1 : 0);
            chk($sformatf("fill valid1 c%0d", i), v1, 0);
            chk($sformatf("fill err12 c%0d", i), e12, 0);
            if (i == 12) EN = 0;
            if (i < 16) step();
        end

        EN = 1; WR = 0; Address = 4'd3;
        step();
        chk("post-fill rd3 valid1", v1, 1);
        chk("post-fill rd3 data1", d1, 32'h0);
        chk("post-fill rd3 valid12", v12, 1);
        chk("post-fill rd3 data12", d12, 32'h0);

        for (int k = 0; k < 18; k++) begin
            EN = tbl[k].en; WR = tbl[k].wr; Address = tbl[k].addr;
            Data_in = tbl[k].din; BE = tbl[k].be;
            step();
            chk($sformatf("vec%0d valid1", k), v1, tbl[k].exp_v);
            chk($sformatf("vec%0d data1", k), d1, tbl[k].exp_d);
            chk($sformatf("vec%0d err1", k), e1, 0);
            chk($sformatf("vec%0d valid12", k), v12, tbl[k].en && !tbl[k].wr);
            chk($sformatf("vec%0d err12", k), e12, tbl[k].en && (tbl[k].addr >= 4'd12));
        end

        EN = 0;
        repeat (3) step();

        // Latency-3 back-to-back reads.
        EN = 1; WR = 0; Address = 4'd0;
        step(); chk("lat3 e0 valid3", v3, 0);
        Address = 4'd1;
        step(); chk("lat3 e1 valid3", v3, 0);
        Address = 4'd2;
        step(); chk("lat3 e2 valid3", v3, 1); chk("lat3 e2 data3", d3, 32'h0A);
        EN = 0;
        step(); chk("lat3 e3 valid3", v3, 1); chk("lat3 e3 data3", d3, 32'h0B);
        step(); chk("lat3 e4 valid3", v3, 1); chk("lat3 e4 data3", d3, 32'h0C);
        chk("lat3 e4 err3", e3, 0);
        step(); chk("lat3 e5 valid3", v3, 0); chk("lat3 e5 hold3", d3, 32'h0C);

        // Out-of-range handling on the 12-word instance.
        EN = 1; WR = 0; Address = 4'd14;
        step();
        chk("oor rd14 data12", d12, 32'h0);
        chk("oor rd14 valid12", v12, 1);
        chk("oor rd14 err12", e12, 1);
        WR = 1; Address = 4'd13; Data_in = 32'h1234_5678; BE = 4'hF;
        step();
        chk("oor wr13 err12", e12, 1);
        chk("oor wr13 valid12", v12, 0);
        EN = 0;
        step();
        chk("oor idle err12", e12, 0);
        EN = 1; WR = 0; Address = 4'd1;
        step();
        chk("oor alias rd1 data12", d12, 32'h0B);
        chk("oor alias rd1 err12", e12, 0);
        Address = 4'd13;
        step();
        chk("oor rd13 data12", d12, 32'h0);
        chk("oor rd13 err12", e12, 1);
        chk("inrange rd13 data1", d1, 32'h1234_5678);
        Address = 4'd11;
        step();
        chk("last rd11 data12", d12, 32'h0);
        chk("last rd11 valid12", v12, 1);
        chk("last rd11 err12", e12, 0);

        // Reset with two latency-3 reads in flight.
        EN = 1; WR = 0; Address = 4'd0;
        step();
        Address = 4'd1;
        step();
        rst = 1'b0; EN = 0;
        #1;
        chk("flush valid3", v3, 0);
        chk("flush busy3", b3, 1);
        chk("flush data3", d3, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("held rst valid3 c%0d", i), v3, 0);
        end
        rst = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            chk($sformatf("refill busy3 c%0d", i), b3, (i < 16) ? 1 : 0);
            chk($sformatf("refill valid3 c%0d", i), v3, 0);
            if (i < 16) step();
        end

        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin
                EN = 1; WR = 0; Address = 4'(j);
            end else begin
                EN = 0;
            end
            step();
            if (j >= 2) begin
                chk($sformatf("refill w%0d valid3", j - 2), v3, 1);
                chk($sformatf("refill w%0d data3", j - 2), d3, INIT3);
            end
            if (j < 16) begin
                chk($sformatf("refill w%0d data1", j), d1, 32'h0);
            end
        end
        step();
        chk("refill drained valid3", v3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
